dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder on the CPU data port. Serves the pipeline's
//   memory-stage loads and stores: byte-lane writes (4-bit strobe), word reads.
//   Has a programmable wait-state count. Drives a stall to the hazard unit
//   while an access is outstanding.
//   Sits between the datapath's M-stage outputs and an internal word array.
// PARAMETERS
//   ADDR_WIDTH   10  word-index bits; depth = 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES   0  extra wait states per access, legal range 0..15
// PORTS
//   clk      in   1   clock, all logic on rising edge
//   rst      in   1   synchronous reset, active-high
//   req      in   1   access request; held by requester until data_ok
//   wr       in   1   1 = store, 0 = load
//   wstrb    in   4   byte-lane write enables; bit i -> wdata[8i+7:8i]
//   addr     in   32  byte address; addr[1:0] ignored
//   wdata    in   32  store data
//   addr_ok  out  1   request accepted this cycle
//   data_ok  out  1   access complete; one-cycle pulse
//   rdata    out  32  load data; valid while data_ok=1, held afterwards
//   busy     out  1   stall request to hazard unit
//   err      out  1   address error; only driven when DMEM_ADDR_CHECK_EN is defined
// BEHAVIOUR
//   - Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
//     On reset: state=IDLE, wait counter=0, addr_ok=0, data_ok=0, rdata=0,
//     busy=0, err=0, request latches cleared.
//   - Array contents are not reset. Simulation initialises the array to 0.
//   - FSM states and transitions:
//     - IDLE -> WAIT when req=1 and WAIT_CYCLES>0; counter loads WAIT_CYCLES.
//     - IDLE -> ACCESS when req=1 and WAIT_CYCLES=0.
//     - WAIT: counter decrements each cycle; goes to ACCESS in the cycle the
//       counter reaches 1.
//     - ACCESS -> DONE unconditionally.
//     - DONE -> IDLE unconditionally.
//   - addr_ok = (state==IDLE) & req, combinational.
//     On the same edge, addr/wr/wstrb/wdata are latched. Later input changes
//     are ignored until DONE.
//   - ACCESS edge: store writes only the strobed lanes at word addr[ADDR_WIDTH+1:2].
//     Load registers that word into rdata.
//   - Store with wstrb=0000 is a no-op that completes normally.
//   - Store does not modify rdata.
//   - Latency: accept cycle T (addr_ok=1) -> data_ok=1 in cycle T+2+WAIT_CYCLES.
//   - busy = req & ~data_ok. The requester sees stall from the request cycle
//     through the cycle before data_ok.
//   - Back-to-back: req still high in the cycle after DONE is a new request and
//     is accepted in that IDLE cycle. Minimum spacing is 3+WAIT_CYCLES cycles.
//   - Address bits above ADDR_WIDTH+1 are ignored (aliasing) unless the
//     macro below is defined.
//   - Reset during WAIT or ACCESS: the access is aborted; a pending store
//     does not reach the array.
//   - WAIT_CYCLES>15 is a configuration error: $error at elaboration.
// CONFIGURATION
//   DMEM_ADDR_CHECK_EN defined:
//     - Latched addr[31:ADDR_WIDTH+2] != 0 marks the access as an address error.
//     - err=1 together with data_ok, for exactly one cycle.
//     - Store is suppressed; load returns rdata=32'h0000_0000.
//     - Latency is unchanged.
//   DMEM_ADDR_CHECK_EN undefined:
//     - err tied to 0; out-of-range addresses alias into the array.
// TESTING
//   - Word round trip, WAIT_CYCLES=0: store addr=0x10 wdata=0xDEADBEEF wstrb=1111,
//     then load 0x10 -> rdata=0xDEADBEEF; data_ok exactly 2 cycles after each addr_ok.
//   - Byte lanes: preload 0x11223344 at 0x20; store wstrb=0101 wdata=0xAABBCCDD;
//     load -> 0x11BB33DD.
//   - Wait states, WAIT_CYCLES=3: load -> data_ok at T+5, busy=1 in cycles T..T+4.
//     Back-to-back second request: addr_ok at T+6.
//   - Reset mid-op, WAIT_CYCLES=3: store 0x55555555 to 0x30, assert rst at T+2;
//     after reset, load 0x30 -> previous value. All outputs 0 during the reset cycle.
//   - Null store: wr=1 wstrb=0000 to 0x40 -> data_ok at T+2, word at 0x40 unchanged.
//   - DMEM_ADDR_CHECK_EN defined, ADDR_WIDTH=10: store to 0x0000_1000 -> err=1 with
//     data_ok, word 0 unchanged; load 0x0000_1000 -> rdata=0.
//     Macro undefined: same store aliases to word 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU M-stage: word reads, byte-lane writes, programmable wait states.
// Optional address-range check enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err
);

    // state  | meaning
    // IDLE   | waiting for req; addr_ok asserted combinationally when req=1
    // WAIT   | burning WAIT_CYCLES wait states on the down-counter
    // ACCESS | array read or strobed write on the closing edge
    // DONE   | data_ok pulse, rdata valid
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} stateE;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gBadWait
        $error("dmem_responder: WAIT_CYCLES=%0d outside 0..15", WAIT_CYCLES);
    end

    stateE                  state;
    stateE                  nextState;
    logic [3:0]             waitCnt;
    logic                   wrQ;
    logic [3:0]             wstrbQ;
    logic [31:0]            wdataQ;
    logic [ADDR_WIDTH-1:0]  idxQ;
    logic [31:0]            rdataQ;
    logic                   addrErrQ;
    logic                   accept;
    logic [31:0]            mem [2**ADDR_WIDTH];

    logic unusedAddr;
    assign unusedAddr = ^{addr[1:0], addr[31:ADDR_WIDTH+2]};

    assign accept = (state == IDLE) && req;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (req) nextState = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (waitCnt == 4'd1) nextState = ACCESS;
            ACCESS:  nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        addr_ok = ~rst & accept;
        data_ok = ~rst & (state == DONE);
        busy    = ~rst & req & ~(state == DONE);
        rdata   = rst ? 32'h0 : rdataQ;
        err     = ~rst & (state == DONE) & addrErrQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= 4'd0;
            wrQ     <= 1'b0;
            wstrbQ  <= 4'd0;
            wdataQ  <= 32'h0;
            idxQ    <= '0;
            rdataQ  <= 32'h0;
        end else begin
            if (accept) begin
                waitCnt <= 4'(WAIT_CYCLES);
                wrQ     <= wr;
                wstrbQ  <= wstrb;
                wdataQ  <= wdata;
                idxQ    <= addr[ADDR_WIDTH+1:2];
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (state == ACCESS && !wrQ) begin
                rdataQ <= addrErrQ ? 32'h0 : mem[idxQ];
            end
        end
    end

`ifdef DMEM_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)         addrErrQ <= 1'b0;
        else if (accept) addrErrQ <= |addr[31:ADDR_WIDTH+2];
    end
`else
    assign addrErrQ = 1'b0;
`endif

    // Array is not reset; a reset in flight blocks the pending store.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && wrQ && !addrErrQ) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrbQ[i]) mem[idxQ][8*i +: 8] <= wdataQ[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states, one with three.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req   [2];
    logic        wr    [2];
    logic [3:0]  wstrb [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        addrOk [2];
    logic        dataOk [2];
    logic [31:0] rdata  [2];
    logic        busy   [2];
    logic        err    [2];

    int passCnt = 0;
    int totalCnt = 0;
    int cycle = 0;
    int acceptCyc [2];

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .wstrb(wstrb[0]),
        .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addrOk[0]), .data_ok(dataOk[0]),
        .rdata(rdata[0]), .busy(busy[0]), .err(err[0]));

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .wstrb(wstrb[1]),
        .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addrOk[1]), .data_ok(dataOk[1]),
        .rdata(rdata[1]), .busy(busy[1]), .err(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt = totalCnt + 1;
        assert (obs === exp) passCnt = passCnt + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input int s, input logic w, input logic [3:0] st,
                          input logic [31:0] a, input logic [31:0] d, input bit keep,
                          output logic [31:0] rd, output int lat, output logic e);
        int  cyc;
        bit  seen;
        req[s] = 1'b1; wr[s] = w; wstrb[s] = st; addr[s] = a; wdata[s] = d;
        @(negedge clk);
        chk("addr_ok", 32'(addrOk[s]), 32'd1);
        acceptCyc[s] = cycle;
        cyc = 0; seen = 0; lat = -1; rd = 32'hx; e = 1'bx;
        while (!seen && cyc < 25) begin
            if (dataOk[s]) begin
                seen = 1; lat = cyc; rd = rdata[s]; e = err[s];
                chk("busy_at_data_ok", 32'(busy[s]), 32'd0);
            end else begin
                chk("busy_stall", 32'(busy[s]), 32'd1);
                @(posedge clk); #1;
                cyc++;
                @(negedge clk);
            end
        end
        chk("data_ok_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        if (!keep) req[s] = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        e;
    int          firstAccept;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; wstrb[i] = 4'h0; addr[i] = 32'h0; wdata[i] = 32'h0;
        end
        rst = 1'b1;
        req[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", 32'(addrOk[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_data_ok", 32'(dataOk[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_err", 32'(err[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req[0] = 1'b0;
        @(posedge clk); #1;

        // Word round trip, no wait states
        access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, rd, lat, e);
        chk("wr_latency", 32'(lat), 32'd2);
        access(0, 1'b0, 4'h0, 32'h10, 32'h0, 0, rd, lat, e);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_word", rd, 32'hDEADBEEF);

        // Byte lanes; a store leaves rdata alone
        access(0, 1'b1, 4'hF, 32'h20, 32'h11223344, 0, rd, lat, e);
        access(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, rd, lat, e);
        chk("store_keeps_rdata", rd, 32'hDEADBEEF);
        access(0, 1'b0, 4'h0, 32'h20, 32'h0, 0, rd, lat, e);
        chk("byte_lanes", rd, 32'h11BB33DD);

        // Null store
        access(0, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 0, rd, lat, e);
        access(0, 1'b1, 4'h0, 32'h40, 32'h12121212, 0, rd, lat, e);
        chk("null_latency", 32'(lat), 32'd2);
        access(0, 1'b0, 4'h0, 32'h40, 32'h0, 0, rd, lat, e);
        chk("null_unchanged", rd, 32'hCAFEF00D);

        // Out-of-range address
        access(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, 0, rd, lat, e);
        access(0, 1'b1, 4'hF, 32'h1000, 32'h76543210, 0, rd, lat, e);
        chk("oor_latency", 32'(lat), 32'd2);
`ifdef DMEM_ADDR_CHECK_EN
        chk("oor_store_err", 32'(e), 32'd1);
        access(0, 1'b0, 4'h0, 32'h0, 32'h0, 0, rd, lat, e);
        chk("oor_word0_kept", rd, 32'h0BADF00D);
        access(0, 1'b0, 4'h0, 32'h1000, 32'h0, 0, rd, lat, e);
        chk("oor_load_err", 32'(e), 32'd1);
        chk("oor_load_zero", rd, 32'h0);
        chk("err_one_cycle", 32'(err[0]), 32'd0);
`else
        chk("alias_err", 32'(e), 32'd0);
        access(0, 1'b0, 4'h0, 32'h0, 32'h0, 0, rd, lat, e);
        chk("alias_word0", rd, 32'h76543210);
`endif

        // Wait states and back-to-back
        access(1, 1'b1, 4'hF, 32'h30, 32'h12345678, 0, rd, lat, e);
        chk("wait_wr_latency", 32'(lat), 32'd5);
        access(1, 1'b0, 4'h0, 32'h30, 32'h0, 1, rd, lat, e);
        firstAccept = acceptCyc[1];
        chk("wait_rd_latency", 32'(lat), 32'd5);
        chk("wait_rd_word", rd, 32'h12345678);
        access(1, 1'b0, 4'h0, 32'h10, 32'h0, 0, rd, lat, e);
        chk("b2b_spacing", 32'(acceptCyc[1] - firstAccept), 32'd6);
        chk("b2b_latency", 32'(lat), 32'd5);
        access(1, 1'b0, 4'h0, 32'h30, 32'h0, 0, rd, lat, e);

        // Reset two cycles into a waited store
        req[1] = 1'b1; wr[1] = 1'b1; wstrb[1] = 4'hF; addr[1] = 32'h30; wdata[1] = 32'h55555555;
        @(negedge clk);
        chk("rst_mid_accept", 32'(addrOk[1]), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr_ok", 32'(addrOk[1]), 32'd0);
        chk("mid_rst_data_ok", 32'(dataOk[1]), 32'd0);
        chk("mid_rst_busy", 32'(busy[1]), 32'd0);
        chk("mid_rst_rdata", rdata[1], 32'h0);
        chk("mid_rst_err", 32'(err[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req[1] = 1'b0;
        @(posedge clk); #1;
        access(1, 1'b0, 4'h0, 32'h30, 32'h0, 0, rd, lat, e);
        chk("mid_rst_store_aborted", rd, 32'h12345678);
        chk("post_rst_latency", 32'(lat), 32'd5);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
